// File: rtl/hazard_shadow_pipe_if.sv
// Bundle between the D/E pipeline control and the hazard shadow unit.
// Protocol: there is no valid/ready pair. Every D-side field describes the
// instruction currently held in D, once per cycle. The unit answers in the
// same cycle: stall=1 means D is held and a bubble enters E, so the master
// presents the same instruction again on the next cycle.
interface hazard_shadow_pipe_if #(
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int SELW = 2
);
  logic [AW-1:0]   D_rs;
  logic [AW-1:0]   D_rt;
  logic [TW-1:0]   D_Tuse_rs;
  logic [TW-1:0]   D_Tuse_rt;
  logic            D_RegWrite;
  logic [AW-1:0]   D_WriteA;
  logic [TW-1:0]   D_Tnew;
  logic            D_MDUStart;
  logic            D_MDUIsDiv;
  logic            D_MDUClass;
  logic [AW-1:0]   E_rs;
  logic [AW-1:0]   E_rt;
  logic            stall;
  logic [SELW-1:0] fwd_D_rs;
  logic [SELW-1:0] fwd_D_rt;
  logic [SELW-1:0] fwd_E_rs;
  logic [SELW-1:0] fwd_E_rt;
  logic            mdu_busy;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_WriteA, D_Tnew,
           D_MDUStart, D_MDUIsDiv, D_MDUClass, E_rs, E_rt,
    input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, mdu_busy
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_WriteA, D_Tnew,
           D_MDUStart, D_MDUIsDiv, D_MDUClass, E_rs, E_rt,
    output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, mdu_busy
  );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// Hazard/forwarding unit driven from a registered shadow of in-flight writers.
// Slot k holds the writer k stages past D (1=E, 2=M, 3=W); its tnew counts
// down as it moves, so forwarding is legal once tnew reaches 0. An internal
// MDU counter models multiply/divide occupancy.
module hazard_shadow_pipe #(
  parameter int NSTAGE   = 3,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int SELW     = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic clk,
  input logic reset,
  hazard_shadow_pipe_if.slave hif
);
  localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [NSTAGE:1]         valid_q, valid_d;
  logic [NSTAGE:1][AW-1:0] waddr_q, waddr_d;
  logic [NSTAGE:1][TW-1:0] tnew_q, tnew_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic haz_rs, haz_rt, busy, stall_c;

  // Youngest matching slot at or beyond 'first' gives the select; a match
  // that is not yet ready masks older ready copies (sel stays 0).
  function automatic logic [SELW-1:0] find_sel(
    input logic [AW-1:0]         r,
    input logic [NSTAGE:1]         v,
    input logic [NSTAGE:1][AW-1:0] wa,
    input logic [NSTAGE:1][TW-1:0] tn,
    input int                      first
  );
    logic [SELW-1:0] s;
    s = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (k >= first && v[k] && wa[k] == r) begin
        s = (tn[k] == '0) ? SELW'(k) : '0;
      end
    end
    if (r == '0) s = '0;
    return s;
  endfunction

  // Hazard when the youngest matching writer produces later than the reader needs it.
  function automatic logic find_haz(
    input logic [AW-1:0]           r,
    input logic [TW-1:0]           tuse,
    input logic [NSTAGE:1]         v,
    input logic [NSTAGE:1][AW-1:0] wa,
    input logic [NSTAGE:1][TW-1:0] tn
  );
    logic h;
    h = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (v[k] && wa[k] == r) h = (tn[k] > tuse);
    end
    if (r == '0) h = 1'b0;
    return h;
  endfunction

  // Lookups, stall decision and outputs, all from registered state plus D inputs.
  always_comb begin
    busy    = (cnt_q != '0);
    haz_rs  = find_haz(hif.D_rs, hif.D_Tuse_rs, valid_q, waddr_q, tnew_q);
    haz_rt  = find_haz(hif.D_rt, hif.D_Tuse_rt, valid_q, waddr_q, tnew_q);
    stall_c = haz_rs || haz_rt || (hif.D_MDUClass && busy);
  end

  assign hif.stall    = stall_c;
  assign hif.mdu_busy = busy;
  assign hif.fwd_D_rs = find_sel(hif.D_rs, valid_q, waddr_q, tnew_q, 1);
  assign hif.fwd_D_rt = find_sel(hif.D_rt, valid_q, waddr_q, tnew_q, 1);
  assign hif.fwd_E_rs = find_sel(hif.E_rs, valid_q, waddr_q, tnew_q, 2);
  assign hif.fwd_E_rt = find_sel(hif.E_rt, valid_q, waddr_q, tnew_q, 2);

  // Next shadow: insert D (or a bubble on stall), age older slots with saturating tnew.
  always_comb begin
    valid_d    = '0;
    waddr_d    = '0;
    tnew_d     = '0;
    if (!stall_c) begin
      valid_d[1] = hif.D_RegWrite && (hif.D_WriteA != '0);
      waddr_d[1] = hif.D_WriteA;
      tnew_d[1]  = hif.D_Tnew;
    end
    for (int k = 2; k <= NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      waddr_d[k] = waddr_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
    end
  end

  // Next MDU count: load on an accepted start, otherwise count down to zero.
  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    if (hif.D_MDUStart && !stall_c) begin
      cnt_d = hif.D_MDUIsDiv ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      waddr_q <= '0;
      tnew_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      tnew_q  <= tnew_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
